m68040_bus_ctrl: RTL

Parametrised 68040 bus-cycle controller that sits between the CPU bus pins and up to NCH on-board slave channels (flash reader, resize/RAM path, UART, FPGA registers). It latches each cycle on TS, decodes the top address nibble to a channel, and drives a simple req/ack handshake to that channel. It terminates the cycle with TA, or with TEA on an unmapped address, a channel error or a timeout. Unlike the single-beat fixed-map controller it replaces, it supports 4-beat line bursts and per-channel burst inhibit.

---
 rtl/m68040_bus_ctrl_if.sv | 38 +++
 rtl/m68040_bus_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/m68040_bus_ctrl_if.sv
// CPU-side bus pins and slave-channel handshake of the 68040 bus-cycle controller.
// The master modport is the controller's view; the slave modport is the CPU/channel side.
interface m68040_bus_ctrl_if #(
    parameter int NCH = 4
);
    logic              ts_n;
    logic [31:0]       a;
    logic              rw;
    logic [1:0]        siz;
    logic [1:0]        tt;
    logic [31:0]       d_in;
    logic [31:0]       d_out;
    logic              d_oe;
    logic              ta_n;
    logic              tea_n;
    logic              tbi_n;
    logic [NCH-1:0]    ch_req;
    logic [31:0]       ch_addr;
    logic              ch_we;
    logic [1:0]        ch_siz;
    logic [31:0]       ch_wdata;
    logic [NCH*32-1:0] ch_rdata;
    logic [NCH-1:0]    ch_ack;
    logic [NCH-1:0]    ch_err;
    logic              busy;

    modport master (
        input  ts_n, a, rw, siz, tt, d_in, ch_rdata, ch_ack, ch_err,
        output d_out, d_oe, ta_n, tea_n, tbi_n, ch_req, ch_addr, ch_we,
               ch_siz, ch_wdata, busy
    );

    modport slave (
        output ts_n, a, rw, siz, tt, d_in, ch_rdata, ch_ack, ch_err,
        input  d_out, d_oe, ta_n, tea_n, tbi_n, ch_req, ch_addr, ch_we,
               ch_siz, ch_wdata, busy
    );
endinterface

// File: rtl/m68040_bus_ctrl.sv
// 68040 bus-cycle controller: decodes a[31:28] to one of NCH channels, runs a
// req/ack handshake per beat (up to 4-beat line bursts) and ends with TA or TEA.
module m68040_bus_ctrl #(
    parameter int                NCH         = 4,
    parameter logic [NCH*4-1:0]  REGION_BASE = {4'h8, 4'h3, 4'h2, 4'h0},
    parameter logic [NCH-1:0]    BURST_EN    = 4'b0001,
    parameter int unsigned       TIMEOUT     = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    m68040_bus_ctrl_if.master    bus
);

    localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_ACCESS,
        S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      a_q, a_d;
    logic             rw_q, rw_d;
    logic [1:0]       siz_q, siz_d;
    logic [1:0]       tt_q, tt_d;
    logic [SELW-1:0]  sel_q, sel_d;
    logic [2:0]       beats_q, beats_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [31:0]      d_out_q, d_out_d;
    logic             d_oe_q, d_oe_d;
    logic             ta_n_q, ta_n_d;
    logic             tea_n_q, tea_n_d;
    logic             tbi_n_q, tbi_n_d;
    logic [NCH-1:0]   ch_req_q, ch_req_d;
    logic [31:0]      ch_addr_q, ch_addr_d;
    logic             ch_we_q, ch_we_d;
    logic [1:0]       ch_siz_q, ch_siz_d;
    logic [31:0]      ch_wdata_q, ch_wdata_d;

    logic             hit;
    logic [SELW-1:0]  hit_idx;
    logic [NCH-1:0]   hit_oh;
    logic [31:0]      rdata_arr [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_rdata
        assign rdata_arr[g] = bus.ch_rdata[32*g +: 32];
    end

    // Region decode: the first (lowest-index) matching nibble selects the channel.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_oh  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!hit && a_q[31:28] == REGION_BASE[4*i +: 4]) begin
                hit       = 1'b1;
                hit_idx   = SELW'(i);
                hit_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        rw_d       = rw_q;
        siz_d      = siz_q;
        tt_d       = tt_q;
        sel_d      = sel_q;
        beats_d    = beats_q;
        cnt_d      = cnt_q;
        d_out_d    = d_out_q;
        d_oe_d     = d_oe_q;
        ta_n_d     = 1'b1;
        tea_n_d    = 1'b1;
        tbi_n_d    = 1'b1;
        ch_req_d   = ch_req_q;
        ch_addr_d  = ch_addr_q;
        ch_we_d    = ch_we_q;
        ch_siz_d   = ch_siz_q;
        ch_wdata_d = ch_wdata_q;

        case (state_q)
            S_IDLE: begin
                d_oe_d = 1'b0;
                if (!bus.ts_n) begin
                    a_d     = bus.a;
                    rw_d    = bus.rw;
                    siz_d   = bus.siz;
                    tt_d    = bus.tt;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ch_wdata_d = bus.d_in;
                if (tt_q == 2'b11) begin
                    d_out_d = 32'hFFFF_FFFF;
                    d_oe_d  = 1'b1;
                    ta_n_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (!hit) begin
                    d_oe_d  = 1'b0;
                    tea_n_d = 1'b0;
                    state_d = S_ERR;
                end else begin
                    sel_d     = hit_idx;
                    ch_req_d  = hit_oh;
                    ch_addr_d = a_q;
                    ch_we_d   = ~rw_q;
                    ch_siz_d  = siz_q;
                    beats_d   = (siz_q == 2'b11 && BURST_EN[hit_idx]) ? 3'd4 : 3'd1;
                    cnt_d     = '0;
                    state_d   = S_ACCESS;
                end
            end
            S_ACCESS: begin
                d_oe_d = 1'b0;
                // Error wins over a simultaneous ack; TA/TEA are registered, one cycle each.
                if (bus.ch_err[sel_q]) begin
                    ch_req_d = '0;
                    tea_n_d  = 1'b0;
                    state_d  = S_ERR;
                end else if (bus.ch_ack[sel_q]) begin
                    ta_n_d = 1'b0;
                    if (rw_q) begin
                        d_out_d = rdata_arr[sel_q];
                        d_oe_d  = 1'b1;
                    end
                    if (siz_q == 2'b11 && !BURST_EN[sel_q]) begin
                        tbi_n_d = 1'b0;
                    end
                    if (beats_q > 3'd1) begin
                        beats_d        = beats_q - 3'd1;
                        ch_addr_d[3:2] = ch_addr_q[3:2] + 2'd1;
                        ch_wdata_d     = bus.d_in;
                    end else begin
                        ch_req_d = '0;
                        state_d  = S_IDLE;
                    end
                end else if (cnt_q == 16'(TIMEOUT)) begin
                    ch_req_d = '0;
                    tea_n_d  = 1'b0;
                    state_d  = S_ERR;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_ERR: begin
                d_oe_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            rw_q       <= 1'b0;
            siz_q      <= '0;
            tt_q       <= '0;
            sel_q      <= '0;
            beats_q    <= '0;
            cnt_q      <= '0;
            d_out_q    <= '0;
            d_oe_q     <= 1'b0;
            ta_n_q     <= 1'b1;
            tea_n_q    <= 1'b1;
            tbi_n_q    <= 1'b1;
            ch_req_q   <= '0;
            ch_addr_q  <= '0;
            ch_we_q    <= 1'b0;
            ch_siz_q   <= '0;
            ch_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            rw_q       <= rw_d;
            siz_q      <= siz_d;
            tt_q       <= tt_d;
            sel_q      <= sel_d;
            beats_q    <= beats_d;
            cnt_q      <= cnt_d;
            d_out_q    <= d_out_d;
            d_oe_q     <= d_oe_d;
            ta_n_q     <= ta_n_d;
            tea_n_q    <= tea_n_d;
            tbi_n_q    <= tbi_n_d;
            ch_req_q   <= ch_req_d;
            ch_addr_q  <= ch_addr_d;
            ch_we_q    <= ch_we_d;
            ch_siz_q   <= ch_siz_d;
            ch_wdata_q <= ch_wdata_d;
        end
    end

    assign bus.d_out    = d_out_q;
    assign bus.d_oe     = d_oe_q;
    assign bus.ta_n     = ta_n_q;
    assign bus.tea_n    = tea_n_q;
    assign bus.tbi_n    = tbi_n_q;
    assign bus.ch_req   = ch_req_q;
    assign bus.ch_addr  = ch_addr_q;
    assign bus.ch_we    = ch_we_q;
    assign bus.ch_siz   = ch_siz_q;
    assign bus.ch_wdata = ch_wdata_q;
    assign bus.busy     = (state_q != S_IDLE);

endmodule
